// File: rtl/bidir_bus_ctrl_pkg.sv
// Shared types and helpers for the bidirectional pad bus controller.
// Holds the FSM state encoding, direction constants and counter sizing.
package bidir_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TURN    = 3'd1,
    ST_DRIVE   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_CAPTURE = 3'd5
  } state_e;

  localparam logic DIR_WR = 1'b1;
  localparam logic DIR_RD = 1'b0;

  // Wide enough to hold the largest window length; never below one bit.
  function automatic int cnt_width(input int turn_cyc, input int hold_cyc,
                                   input int settle_cyc);
    int m;
    m = turn_cyc;
    if (hold_cyc > m) m = hold_cyc;
    if (settle_cyc > m) m = settle_cyc;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of quasi-static asynchronous inputs.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/bidir_bus_ctrl.sv
// Sequencer for an IOBUF-based bidirectional pad bus: turnaround, drive-hold
// and settle windows guarantee the bus is only driven in the DRIVE state.
module bidir_bus_ctrl
  import bidir_bus_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int TURN_CYC   = 2,
  parameter int HOLD_CYC   = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [DATA_W-1:0] pad_o,
  output logic [DATA_W-1:0] pad_t,
  input  logic [DATA_W-1:0] pad_i
);

  // Handshake: a request is taken on a clock edge where req_valid & req_ready;
  // req_ready is high only in IDLE. rsp_valid is a single-cycle pulse with no
  // backpressure.

  localparam int CW = cnt_width(TURN_CYC, HOLD_CYC, SETTLE_CYC);
  localparam logic [CW-1:0] TURN_LD   = CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] pad_o_q, pad_o_d;
  logic [DATA_W-1:0] pad_t_q, pad_t_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [DATA_W-1:0] pad_i_s;

  sync_2ff #(.W(DATA_W)) u_pad_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pad_i),
    .q     (pad_i_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wdata_q     <= '0;
      pad_o_q     <= '0;
      pad_t_q     <= '1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      pad_o_q     <= pad_o_d;
      pad_t_q     <= pad_t_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wdata_d = req_wdata;
          if (req_wr == DIR_WR) state_d = (TURN_CYC == 0) ? ST_DRIVE : ST_TURN;
          else                  state_d = ST_SETTLE;
        end
      end
      ST_TURN: begin
        if (cnt_q == '0) state_d = ST_DRIVE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DRIVE: begin
        if (cnt_q == '0) state_d = ST_RELEASE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RELEASE: state_d = ST_IDLE;
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          rsp_rdata_d = pad_i_s;
          state_d     = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // Each window counts down from its length minus one, loaded on entry.
    if (state_d != state_q) begin
      case (state_d)
        ST_TURN:   cnt_d = TURN_LD;
        ST_DRIVE:  cnt_d = HOLD_LD;
        ST_SETTLE: cnt_d = SETTLE_LD;
        default:   cnt_d = '0;
      endcase
    end
  end

  // Registered pad controls are decoded from the next state so they line up
  // with the state register.
  always_comb begin
    pad_t_d     = {DATA_W{state_d != ST_DRIVE}};
    pad_o_d     = (state_d == ST_DRIVE) ? wdata_d : pad_o_q;
    rsp_valid_d = (state_d == ST_RELEASE) || (state_d == ST_CAPTURE);
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign pad_o     = pad_o_q;
  assign pad_t     = pad_t_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Directed bench for bidir_bus_ctrl: per-cycle vector table plus hand-written
// reset-abort and zero-turnaround sequences.
module tb_bidir_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       req_valid = 1'b0, req_wr = 1'b0;
  logic [7:0] req_wdata = 8'h00, pad_i = 8'h00;
  logic       req_ready, rsp_valid, busy;
  logic [7:0] rsp_rdata, pad_o, pad_t;

  logic       req_valid0 = 1'b0, req_wr0 = 1'b0;
  logic [7:0] req_wdata0 = 8'h00, pad_i0 = 8'h00;
  logic       req_ready0, rsp_valid0, busy0;
  logic [7:0] rsp_rdata0, pad_o0, pad_t0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bidir_bus_ctrl #(.DATA_W(8), .TURN_CYC(2), .HOLD_CYC(4), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .busy(busy), .pad_o(pad_o), .pad_t(pad_t),
    .pad_i(pad_i)
  );

  bidir_bus_ctrl #(.DATA_W(8), .TURN_CYC(0), .HOLD_CYC(4), .SETTLE_CYC(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_wr(req_wr0), .req_wdata(req_wdata0), .rsp_valid(rsp_valid0),
    .rsp_rdata(rsp_rdata0), .busy(busy0), .pad_o(pad_o0), .pad_t(pad_t0),
    .pad_i(pad_i0)
  );

  typedef struct {
    logic       v;
    logic       wr;
    logic [7:0] wd;
    logic [7:0] pi;
    logic [7:0] t;
    logic [7:0] o;
    logic       rv;
    logic       rdy;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // fields: valid wr wdata pad_i | pad_t pad_o rsp_valid ready rsp_rdata
    vecs[0]  = '{1'b1, 1'b1, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 8'h3C, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 8'h3C, 8'h00, 8'hA5, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 8'h3C, 8'h00, 8'hA5, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 8'h3C, 8'h00, 8'hA5, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 8'h3C, 8'h00, 8'hA5, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 8'h3C, 8'hFF, 8'hA5, 1'b1, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 8'h3C, 8'hFF, 8'hA5, 1'b0, 1'b1, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 8'h3C, 8'hFF, 8'hA5, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 8'h3C, 8'hFF, 8'hA5, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 8'h3C, 8'hFF, 8'hA5, 1'b1, 1'b0, 8'h3C};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 8'h3C, 8'hFF, 8'hA5, 1'b0, 1'b1, 8'h3C};
    vecs[12] = '{1'b1, 1'b1, 8'h5A, 8'h3C, 8'hFF, 8'hA5, 1'b0, 1'b0, 8'h3C};
    vecs[13] = '{1'b1, 1'b0, 8'h00, 8'h3C, 8'hFF, 8'hA5, 1'b0, 1'b0, 8'h3C};
    vecs[14] = '{1'b1, 1'b0, 8'h00, 8'h3C, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h3C};
    vecs[15] = '{1'b1, 1'b0, 8'h00, 8'h3C, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h3C};
    vecs[16] = '{1'b1, 1'b0, 8'h00, 8'h3C, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h3C};
    vecs[17] = '{1'b1, 1'b0, 8'h00, 8'h3C, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h3C};
    vecs[18] = '{1'b1, 1'b0, 8'h00, 8'h3C, 8'hFF, 8'h5A, 1'b1, 1'b0, 8'h3C};
    vecs[19] = '{1'b1, 1'b0, 8'h00, 8'hC3, 8'hFF, 8'h5A, 1'b0, 1'b1, 8'h3C};
    vecs[20] = '{1'b1, 1'b0, 8'h00, 8'hC3, 8'hFF, 8'h5A, 1'b0, 1'b0, 8'h3C};
    vecs[21] = '{1'b0, 1'b0, 8'h00, 8'hC3, 8'hFF, 8'h5A, 1'b0, 1'b0, 8'h3C};
    vecs[22] = '{1'b0, 1'b0, 8'h00, 8'hC3, 8'hFF, 8'h5A, 1'b1, 1'b0, 8'hC3};
    vecs[23] = '{1'b0, 1'b0, 8'h00, 8'hC3, 8'hFF, 8'h5A, 1'b0, 1'b1, 8'hC3};

    // Reset asserted between clock edges must take effect without an edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pad_t", pad_t, 8'hFF);
    chk("rst_pad_o", pad_o, 8'h00);
    chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'h00);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_pad_t0", pad_t0, 8'hFF);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", {7'd0, req_ready}, 8'h01);
    chk("post_rst_busy", {7'd0, busy}, 8'h00);

    // Write A5, read 3C, then write 5A with a read held behind it.
    for (int i = 0; i < 24; i++) begin
      req_valid = vecs[i].v;
      req_wr    = vecs[i].wr;
      req_wdata = vecs[i].wd;
      pad_i     = vecs[i].pi;
      tick();
      chk($sformatf("v%0d_pad_t", i), pad_t, vecs[i].t);
      chk($sformatf("v%0d_pad_o", i), pad_o, vecs[i].o);
      chk($sformatf("v%0d_rsp_valid", i), {7'd0, rsp_valid}, {7'd0, vecs[i].rv});
      chk($sformatf("v%0d_ready", i), {7'd0, req_ready}, {7'd0, vecs[i].rdy});
      chk($sformatf("v%0d_busy", i), {7'd0, busy}, {7'd0, ~vecs[i].rdy});
      chk($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].rd);
    end

    // Abort a write with reset during its second DRIVE cycle.
    req_valid = 1'b1; req_wr = 1'b1; req_wdata = 8'h11;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_drive2_pad_t", pad_t, 8'h00);
    chk("abort_drive2_pad_o", pad_o, 8'h11);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_async_pad_t", pad_t, 8'hFF);
    chk("abort_async_pad_o", pad_o, 8'h00);
    chk("abort_async_ready", {7'd0, req_ready}, 8'h01);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("abort_no_rsp%0d", i), {7'd0, rsp_valid}, 8'h00);
      chk($sformatf("abort_idle%0d", i), {7'd0, busy}, 8'h00);
      chk($sformatf("abort_pad_t%0d", i), pad_t, 8'hFF);
    end

    // Zero-turnaround instance drives straight after accept.
    req_valid0 = 1'b1; req_wr0 = 1'b1; req_wdata0 = 8'hFF;
    tick();
    req_valid0 = 1'b0; req_wdata0 = 8'h00;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t0_drive%0d_pad_t", i), pad_t0, 8'h00);
      chk($sformatf("t0_drive%0d_pad_o", i), pad_o0, 8'hFF);
      chk($sformatf("t0_drive%0d_rsp", i), {7'd0, rsp_valid0}, 8'h00);
      tick();
    end
    chk("t0_release_pad_t", pad_t0, 8'hFF);
    chk("t0_release_rsp", {7'd0, rsp_valid0}, 8'h01);
    chk("t0_release_pad_o", pad_o0, 8'hFF);
    tick();
    chk("t0_idle_rsp", {7'd0, rsp_valid0}, 8'h00);
    chk("t0_idle_ready", {7'd0, req_ready0}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
